// File: rtl/fifo_wr_arb_if.sv
// fifo_wr_arb_if: bundle between NREQ write requesters, the arbiter and the
// write port of one fifo_scd instance.
//   req       requester -> arb : per-requester request, held until ack
//   din       requester -> arb : packed data, requester i on din[i*DW +: DW]
//   ack       arb -> requester : one-hot, word taken at this posedge
//   fifo_full fifo -> arb      : fifo_scd full flag
//   fifo_we   arb -> fifo      : write enable
//   fifo_din  arb -> fifo      : write data
//   grant_id  arb -> status    : index of the last requester written
//   busy      arb -> status    : burst lock held (arbiter FSM state)
// Handshake: a word moves on every posedge where req[i] and ack[i] are both
// high; ack is combinational, so the requester must hold req and its data
// stable until it sees ack, and may change them after that posedge.
interface fifo_wr_arb_if #(
  parameter int NREQ = 4,
  parameter int DW   = 8
);
  localparam int IW = $clog2(NREQ);

  logic [NREQ-1:0]    req;
  logic [NREQ*DW-1:0] din;
  logic [NREQ-1:0]    ack;
  logic               fifo_full;
  logic               fifo_we;
  logic [DW-1:0]      fifo_din;
  logic [IW-1:0]      grant_id;
  logic               busy;

  // Arbiter side.
  modport slave (
    input  req, din, fifo_full,
    output ack, fifo_we, fifo_din, grant_id, busy
  );

  // Requester / fifo / environment side.
  modport master (
    output req, din, fifo_full,
    input  ack, fifo_we, fifo_din, grant_id, busy
  );
endinterface

// File: rtl/fifo_wr_arb.sv
// fifo_wr_arb: round-robin arbiter sharing one fifo_scd write port between
// NREQ requesters. A granted requester may keep the port for up to BURST
// consecutive writes (FSM LOCKED) before ownership rotates.
// Ports:
//   clk    : clock, all state updates on posedge
//   rst_n  : asynchronous active-low reset
//   bus    : fifo_wr_arb_if.slave (req/din/ack, fifo_full/we/din, status)
// The FSM state (FREE/LOCKED) is visible on bus.busy.
module fifo_wr_arb #(
  parameter int NREQ  = 4,
  parameter int DW    = 8,
  parameter int BURST = 2
) (
  input logic          clk,
  input logic          rst_n,
  fifo_wr_arb_if.slave bus
);
  localparam int IW = $clog2(NREQ);
  localparam int CW = (BURST > 1) ? $clog2(BURST) : 1;

  typedef enum logic {S_FREE = 1'b0, S_LOCKED = 1'b1} state_t;

  state_t          r_state, w_state_nxt;
  logic [IW-1:0]   r_ptr, w_ptr_nxt;
  logic [IW-1:0]   r_owner, w_owner_nxt;
  logic [IW-1:0]   r_grant_id, w_grant_id_nxt;
  logic [CW-1:0]   r_cnt, w_cnt_nxt;
  logic [IW-1:0]   w_sel;
  logic            w_found;
  logic            w_hold_owner;
  logic            w_any;
  logic            w_wr;
  logic            w_same;
  logic            w_last;

  // (base + k) mod NREQ without a divider; base < NREQ and k < NREQ.
  function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= NREQ) s = s - NREQ;
    return IW'(s);
  endfunction

  // Selection: the lock owner keeps the port while it still requests,
  // otherwise the first requester at or after ptr wins. An owner that drops
  // req loses the port in the same cycle through the fallback search.
  always_comb begin
    w_hold_owner = (r_state == S_LOCKED) && bus.req[r_owner];
    w_sel        = '0;
    w_found      = 1'b0;
    if (w_hold_owner) begin
      w_sel = r_owner;
    end else begin
      for (int k = 0; k < NREQ; k++) begin
        if (!w_found && bus.req[wrap_add(r_ptr, k)]) begin
          w_sel   = wrap_add(r_ptr, k);
          w_found = 1'b1;
        end
      end
    end
  end

  assign w_any = |bus.req;
  assign w_wr  = w_any && !bus.fifo_full;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_FREE;
      r_ptr      <= '0;
      r_owner    <= '0;
      r_cnt      <= '0;
      r_grant_id <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_ptr      <= w_ptr_nxt;
      r_owner    <= w_owner_nxt;
      r_cnt      <= w_cnt_nxt;
      r_grant_id <= w_grant_id_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    // Continuing the owner's burst vs starting a fresh one.
    w_same         = (r_state == S_LOCKED) && (w_sel == r_owner);
    w_last         = w_same ? ((int'(r_cnt) + 1) >= BURST) : (BURST == 1);
    w_state_nxt    = r_state;
    w_ptr_nxt      = r_ptr;
    w_owner_nxt    = r_owner;
    w_cnt_nxt      = r_cnt;
    w_grant_id_nxt = r_grant_id;
    if (w_wr) begin
      w_grant_id_nxt = w_sel;
      w_ptr_nxt      = (w_sel == IW'(NREQ - 1)) ? '0 : w_sel + 1'b1;
      if (w_last) begin
        w_state_nxt = S_FREE;
        w_cnt_nxt   = '0;
      end else begin
        w_state_nxt = S_LOCKED;
        w_owner_nxt = w_sel;
        w_cnt_nxt   = w_same ? r_cnt + 1'b1 : CW'(1);
      end
    end else if ((r_state == S_LOCKED) && !bus.req[r_owner]) begin
      // Owner abandoned its burst while nothing was written.
      w_state_nxt = S_FREE;
      w_cnt_nxt   = '0;
    end
  end

  // Outputs. ack/we are gated by rst_n so they are quiet during reset.
  always_comb begin
    bus.ack = '0;
    if (rst_n && w_wr) bus.ack[w_sel] = 1'b1;
    bus.fifo_we  = rst_n && w_wr;
    bus.fifo_din = bus.din[int'(w_sel)*DW +: DW];
    bus.grant_id = r_grant_id;
    bus.busy     = (r_state == S_LOCKED);
  end
endmodule
